// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Each request is judged against the flags from before the edge.
    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dout_d = dout_q;
        if (wr_ok) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (rd_ok) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
            dout_d = mem_q[rptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q[AW-1:0]] <= data_in;
        end
    end

    assign data_out = dout_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          w_en    = 1'b0;
    logic          r_en    = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (w_en),
        .r_en    (r_en),
        .data_in (data_in),
        .data_out(data_out),
        .full    (full),
        .empty   (empty)
    );

    int            checks   = 0;
    int            passed   = 0;
    int            wr_total = 0;
    int            rd_total = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] dout_m   = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_empty"}, DW'(empty), DW'(q.size() == 0));
        check({tag, "_full"}, DW'(full), DW'(q.size() == DEPTH));
        check({tag, "_dout"}, data_out, dout_m);
    endtask

    task automatic step(input logic w, input logic r,
                        input logic [DW-1:0] d, input string tag);
        bit wok;
        bit rok;
        @(negedge clk);
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        wok = w && (q.size() < DEPTH);
        rok = r && (q.size() != 0);
        if (rok) begin
            dout_m = q.pop_front();
            rd_total++;
        end
        if (wok) begin
            q.push_back(d);
            wr_total++;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_start;

        // Reset held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all("rst_hold");
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, "idle");
        step(1'b0, 1'b0, 8'h00, "idle");

        // Fill and overflow
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), "fill");
        end
        check("fill_full", DW'(full), 8'h01);
        step(1'b1, 1'b0, 8'hAA, "ovf");
        check("ovf_full", DW'(full), 8'h01);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain_order", data_out, DW'(i));
        end
        check("drain_empty", DW'(empty), 8'h01);

        // Underflow
        step(1'b0, 1'b1, 8'h00, "udf");
        check("udf_hold", data_out, 8'h08);
        step(1'b1, 1'b0, 8'h5C, "udf_wr");
        step(1'b0, 1'b1, 8'h00, "udf_rd");
        check("udf_new", data_out, 8'h5C);

        // Simultaneous at occupancy 3
        step(1'b1, 1'b0, 8'h11, "occ3_wr");
        step(1'b1, 1'b0, 8'h22, "occ3_wr");
        step(1'b1, 1'b0, 8'h33, "occ3_wr");
        step(1'b1, 1'b1, 8'h44, "occ3_rw");
        check("occ3_rd1", data_out, 8'h11);
        step(1'b1, 1'b1, 8'h55, "occ3_rw");
        check("occ3_rd2", data_out, 8'h22);
        step(1'b0, 1'b1, 8'h00, "occ3_dr");
        check("occ3_rd3", data_out, 8'h33);
        step(1'b0, 1'b1, 8'h00, "occ3_dr");
        step(1'b0, 1'b1, 8'h00, "occ3_dr");
        check("occ3_last", data_out, 8'h55);

        // Simultaneous while full
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(8'h80 + i), "full_fill");
        end
        step(1'b1, 1'b1, 8'hEE, "full_rw");
        check("full_rw_full", DW'(full), 8'h00);
        check("full_rw_dout", data_out, 8'h80);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "full_dr");
        end
        check("full_no_ee", data_out, 8'h87);

        // Simultaneous while empty
        step(1'b1, 1'b1, 8'h3C, "empty_rw");
        check("empty_rw_empty", DW'(empty), 8'h00);
        check("empty_rw_nobyp", data_out, 8'h87);
        step(1'b0, 1'b1, 8'h00, "empty_rd");
        check("empty_rd_val", data_out, 8'h3C);

        // Wrap-around bursts with alternating enables
        wr_start = wr_total;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 30; c++) begin
                step(c % 2 == 0, c % 2 == 1, DW'($urandom), "burst");
            end
            @(negedge clk);
            w_en = 1'b0;
            r_en = 1'b0;
            #50;
        end
        check("wraps", DW'((wr_total - wr_start) >= 3 * DEPTH), 8'h01);

        // Random enables
        for (int c = 0; c < 200; c++) begin
            step(1'($urandom), 1'($urandom), DW'($urandom), "rand");
        end

        // Mid-operation reset
        for (int k = 0; k <= DEPTH && q.size() != 0; k++) begin
            step(1'b0, 1'b1, 8'h00, "pre_drain");
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, DW'(8'hC0 + i), "mid_fill");
        end
        step(1'b0, 1'b0, 8'h00, "mid_idle");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        dout_m = '0;
        check_all("midrst");
        check("midrst_empty", DW'(empty), 8'h01);
        check("midrst_dout", data_out, 8'h00);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h77, "post_wr");
        step(1'b0, 1'b1, 8'h00, "post_rd");
        check("post_val", data_out, 8'h77);
        check("post_empty", DW'(empty), 8'h01);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
